// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg -- shared constants and types for the parallel block FIR.
//
// Holds the default geometry (lanes, taps, widths, fractional bits), the
// default sample/coefficient types, the rounding constant and the encoding
// of the coefficient bookkeeping state.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int P_DEF     = 6;   // samples per block
    localparam int NTAPS_DEF = 16;  // FIR length
    localparam int DW_DEF    = 16;  // sample / output width
    localparam int CW_DEF    = 16;  // coefficient width
    localparam int FRAC_DEF  = 15;  // coefficient fractional bits

    typedef logic signed [DW_DEF-1:0] sample_t;
    typedef logic signed [CW_DEF-1:0] coef_t;

    // Half an LSB of the output, added before the arithmetic right shift.
    localparam int ROUND_DEF = 1 << (FRAC_DEF - 1);

    // Tracks whether coefficients changed since the last accepted block.
    typedef enum logic {
        COEF_LOADED = 1'b0,
        COEF_DIRTY  = 1'b1
    } coef_state_t;

    // Rounding constant for an arbitrary fractional width (0 when FRAC=0).
    function automatic int round_const(input int frac);
        return (frac > 0) ? (1 << (frac - 1)) : 0;
    endfunction

endpackage

// File: rtl/fir_lane.sv
// ---------------------------------------------------------------------------
// fir_lane -- one output lane of the parallel FIR.
//
// Stage 1 registers the NTAPS products x[n-k]*h[k]; stage 2 registers the
// rounded, shifted and width-reduced sum.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en_mul     load the product registers (block accepted this cycle)
//   en_sum     load the output register (stage 1 holds a valid block)
//   x_win      NTAPS samples, slot k = x[n-k]
//   coef       NTAPS coefficients, slot k = h[k]
//   y          lane result
//
// Build option: define FIR_SAT_EN to saturate the result to DW bits;
// otherwise the result wraps (keeps the low DW bits).
// ---------------------------------------------------------------------------
module fir_lane
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_mul,
    input  logic                  en_sum,
    input  logic [NTAPS*DW-1:0]   x_win,
    input  logic [NTAPS*CW-1:0]   coef,
    output logic [DW-1:0]         y
);

    localparam int PW = DW + CW;
    // Wide enough that the sum of NTAPS full-scale products cannot overflow.
    localparam int AW = PW + $clog2(NTAPS);
    localparam logic signed [AW-1:0] RND = AW'(round_const(FRAC));
`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] Y_MAX = (AW'(1) << (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] Y_MIN = -(AW'(1) << (DW - 1));
`endif

    logic signed [PW-1:0] prod_arr [NTAPS];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rnd_shift;
    logic [DW-1:0]        y_d;
    logic [DW-1:0]        y_q;

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            logic signed [PW-1:0] prod_d;
            logic signed [PW-1:0] prod_q;

            always_comb begin
                prod_d = PW'($signed(x_win[gi*DW +: DW])) * PW'($signed(coef[gi*CW +: CW]));
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_q <= '0;
                end else if (en_mul) begin
                    prod_q <= prod_d;
                end
            end

            assign prod_arr[gi] = prod_q;
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + AW'(prod_arr[k]);
        end
        rnd_shift = (acc + RND) >>> FRAC;
    end

    always_comb begin
`ifdef FIR_SAT_EN
        if (rnd_shift > Y_MAX) begin
            y_d = Y_MAX[DW-1:0];
        end else if (rnd_shift < Y_MIN) begin
            y_d = Y_MIN[DW-1:0];
        end else begin
            y_d = rnd_shift[DW-1:0];
        end
`else
        y_d = rnd_shift[DW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else if (en_sum) begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/parallel_fir.sv
// ---------------------------------------------------------------------------
// parallel_fir -- block-parallel FIR filter, P samples per clock.
//
// Keeps the last NTAPS-1 accepted samples, forms a sliding window with the
// incoming block and feeds one fir_lane per output sample. Two-cycle latency,
// one block per cycle, no backpressure.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    x_blk carries a new block
//   x_blk       P signed samples, lane 0 oldest
//   flush       clear the sample history (before an accompanying block)
//   coef_we     write coef_data into tap coef_addr (out-of-range ignored)
//   out_valid   y_blk carries a result block
//   y_blk       P signed results, lane order as x_blk
//
// Build option: FIR_SAT_EN selects saturating output (see fir_lane).
// ---------------------------------------------------------------------------
module parallel_fir
    import fir_pkg::*;
#(
    parameter int P     = P_DEF,
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [P*DW-1:0]             x_blk,
    input  logic                        flush,
    input  logic                        coef_we,
    input  logic [$clog2(NTAPS)-1:0]    coef_addr,
    input  logic [CW-1:0]               coef_data,
    output logic                        out_valid,
    output logic [P*DW-1:0]             y_blk
);

    localparam int HLEN   = NTAPS - 1;
    localparam int WLEN   = HLEN + P;
    localparam int ADDR_W = $clog2(NTAPS);

    logic [DW-1:0]    hist_d [HLEN];
    logic [DW-1:0]    hist_q [HLEN];
    logic [DW-1:0]    win    [WLEN];   // win[i] = sample at time P*m - HLEN + i
    logic [CW-1:0]    coef_d [NTAPS];
    logic [CW-1:0]    coef_q [NTAPS];
    logic [NTAPS*CW-1:0] coef_flat;
    logic             v1_d, v1_q;
    logic             v2_d, v2_q;
    logic             coef_hit;
    coef_state_t      coef_state_d, coef_state_q;

    assign coef_hit = coef_we && ({{(32-ADDR_W){1'b0}}, coef_addr} < 32'(NTAPS));

    // A flush in the same cycle as a block zeroes the history the block sees.
    always_comb begin
        for (int i = 0; i < HLEN; i++) begin
            win[i] = flush ? '0 : hist_q[i];
        end
        for (int j = 0; j < P; j++) begin
            win[HLEN + j] = x_blk[j*DW +: DW];
        end
    end

    always_comb begin
        for (int i = 0; i < HLEN; i++) begin
            if (in_valid) begin
                hist_d[i] = win[i + P];
            end else if (flush) begin
                hist_d[i] = '0;
            end else begin
                hist_d[i] = hist_q[i];
            end
        end
    end

    // Stage 1 samples coef_q, so a write in the same cycle as a block only
    // affects later blocks.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            coef_d[k] = coef_q[k];
        end
        if (coef_hit) begin
            coef_d[coef_addr] = coef_data;
        end
    end

    always_comb begin
        v1_d = in_valid;
        v2_d = v1_q;
    end

    always_comb begin
        coef_state_d = coef_state_q;
        if (coef_we) begin
            coef_state_d = COEF_DIRTY;
        end else if (in_valid) begin
            coef_state_d = COEF_LOADED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HLEN; i++) begin
                hist_q[i] <= '0;
            end
            for (int k = 0; k < NTAPS; k++) begin
                coef_q[k] <= '0;
            end
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            coef_state_q <= COEF_LOADED;
        end else begin
            hist_q       <= hist_d;
            coef_q       <= coef_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            coef_state_q <= coef_state_d;
        end
    end

    assign out_valid = v2_q;

    a_coef_dirty: assert property (@(posedge clk) disable iff (rst)
        coef_we |=> (coef_state_q == COEF_DIRTY));
    a_coef_loaded: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !coef_we) |=> (coef_state_q == COEF_LOADED));

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
            assign coef_flat[gi*CW +: CW] = coef_q[gi];
        end

        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic [NTAPS*DW-1:0] x_win;

            // Lane gi, tap gj needs x[P*m + gi - gj].
            for (genvar gj = 0; gj < NTAPS; gj++) begin : g_win
                assign x_win[gj*DW +: DW] = win[HLEN + gi - gj];
            end

            fir_lane #(
                .NTAPS (NTAPS),
                .DW    (DW),
                .CW    (CW),
                .FRAC  (FRAC)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .en_mul (in_valid),
                .en_sum (v1_q),
                .x_win  (x_win),
                .coef   (coef_flat),
                .y      (y_blk[gi*DW +: DW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_parallel_fir.sv
// ---------------------------------------------------------------------------
// tb_parallel_fir -- self-checking bench for parallel_fir (P=6, NTAPS=16).
//
// A sample-level reference model computes every expected output block from
// the FIR definition; a compare process checks out_valid/y_blk each cycle.
// Hand-computed literals pin selected output blocks of each scenario.
// ---------------------------------------------------------------------------
module tb_parallel_fir;

    localparam int P      = 6;
    localparam int NTAPS  = 16;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int FRAC   = 15;
    localparam int ADDR_W = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [P*DW-1:0]     x_blk;
    logic                flush;
    logic                coef_we;
    logic [ADDR_W-1:0]   coef_addr;
    logic [CW-1:0]       coef_data;
    logic                out_valid;
    logic [P*DW-1:0]     y_blk;

    parallel_fir #(
        .P     (P),
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW),
        .FRAC  (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x_blk     (x_blk),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y_blk     (y_blk)
    );

    typedef struct {
        int              due;
        logic [P*DW-1:0] y;
    } exp_t;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic            rst_seen = 1'b0;
    longint          h_m [NTAPS];
    longint          hist [$];
    exp_t            exp_q [$];
    logic [P*DW-1:0] got [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [P*DW-1:0] b, input int j);
        return b[j*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] model_out(input longint acc);
        longint r;
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef FIR_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[DW-1:0];
    endfunction

    // Reference model: updates at each rising edge from the sampled inputs.
    initial begin
        int              n;
        longint          acc;
        logic [P*DW-1:0] yb;
        exp_t            e;
        for (int k = 0; k < NTAPS; k++) h_m[k] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                exp_q.delete();
                for (int k = 0; k < NTAPS; k++) h_m[k] = 0;
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                if (flush) hist.delete();
                if (in_valid) begin
                    for (int j = 0; j < P; j++) hist.push_back(longint'($signed(x_blk[j*DW +: DW])));
                    for (int j = 0; j < P; j++) begin
                        n   = hist.size() - P + j;
                        acc = 0;
                        for (int k = 0; k < NTAPS; k++) begin
                            if (n - k >= 0) acc += h_m[k] * hist[n - k];
                        end
                        yb[j*DW +: DW] = model_out(acc);
                    end
                    e.due = cyc + 2;
                    e.y   = yb;
                    exp_q.push_back(e);
                    while (hist.size() > NTAPS - 1) void'(hist.pop_front());
                end
                if (coef_we && ({28'd0, coef_addr} < NTAPS)) h_m[coef_addr] = longint'($signed(coef_data));
            end
            cyc++;
        end
    end

    // Compare process: checks outputs in the middle of every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("out_valid_expected", 128'(out_valid), 128'(1'b1));
                check("y_blk", 128'(y_blk), 128'(exp_q[0].y));
                got.push_back(y_blk);
                void'(exp_q.pop_front());
            end else begin
                check("out_valid_idle", 128'(out_valid), 128'(1'b0));
                if (rst_seen) check("y_blk_in_reset", 128'(y_blk), 128'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [P*DW-1:0] x, input logic f,
                         input logic we, input logic [ADDR_W-1:0] a, input logic [CW-1:0] d);
        in_valid  = v;
        x_blk     = x;
        flush     = f;
        coef_we   = we;
        coef_addr = a;
        coef_data = d;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic blk(input logic [P*DW-1:0] x);
        drive(1'b1, x, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input int k, input logic [CW-1:0] d);
        drive(1'b0, '0, 1'b0, 1'b1, ADDR_W'(k), d);
    endtask

    task automatic load_ramp_coefs();
        for (int k = 0; k < NTAPS; k++) wr(k, CW'(256 * k));
    endtask

    task automatic chk_lit(input string name, input int idx, input int j, input logic [DW-1:0] req);
        if (idx >= got.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: output block %0d missing (got %0d blocks)", name, idx, got.size());
        end else begin
            check(name, 128'(lane(got[idx], j)), 128'(req));
        end
    endtask

    function automatic logic [P*DW-1:0] fill(input logic [DW-1:0] v);
        logic [P*DW-1:0] r;
        for (int j = 0; j < P; j++) r[j*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [P*DW-1:0] impulse();
        logic [P*DW-1:0] r;
        r = '0;
        r[DW-1:0] = 16'h7FFF;
        return r;
    endfunction

    function automatic logic [P*DW-1:0] ramp();
        logic [P*DW-1:0] r;
        for (int j = 0; j < P; j++) r[j*DW +: DW] = DW'(16'h0400 * (j + 1));
        return r;
    endfunction

    initial begin
        int              base;
        logic [DW-1:0]   sat_exp;
`ifdef FIR_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'hFFE0;
`endif
        rst = 1'b1; in_valid = 1'b0; x_blk = '0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick();
        tick();
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_y_blk", 128'(y_blk), 128'(0));
        rst = 1'b0;

        // Impulse, back-to-back blocks: y[n] = 256*n for n < 16.
        load_ramp_coefs();
        base = got.size();
        blk(impulse());
        for (int b = 0; b < 3; b++) blk('0);
        idle(4);
        $display("impulse: %0d output blocks", got.size() - base);
        chk_lit("imp_b0_l1", base + 0, 1, 16'd256);
        chk_lit("imp_b1_l5", base + 1, 5, 16'd2816);
        chk_lit("imp_b2_l3", base + 2, 3, 16'd3840);
        chk_lit("imp_b2_l4", base + 2, 4, 16'd0);
        chk_lit("imp_b3_l0", base + 3, 0, 16'd0);

        // Same impulse with three idle cycles between blocks.
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
        base = got.size();
        blk(impulse());
        for (int b = 0; b < 3; b++) begin
            idle(3);
            blk('0);
        end
        idle(4);
        $display("gapped: %0d output blocks", got.size() - base);
        chk_lit("gap_b0_l5", base + 0, 5, 16'd1280);
        chk_lit("gap_b1_l0", base + 1, 0, 16'd1536);
        chk_lit("gap_b2_l3", base + 2, 3, 16'd3840);
        check("gap_block_count", 128'(got.size() - base), 128'(4));

        // Full-scale input and coefficients.
        for (int k = 0; k < NTAPS; k++) wr(k, 16'h7FFF);
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
        base = got.size();
        for (int b = 0; b < 4; b++) blk(fill(16'h7FFF));
        idle(4);
        $display("saturation: %0d output blocks", got.size() - base);
        chk_lit("sat_b2_l5", base + 2, 5, sat_exp);
        chk_lit("sat_b3_l0", base + 3, 0, sat_exp);
        chk_lit("sat_b3_l5", base + 3, 5, sat_exp);

        // Coefficient writes alongside blocks, then flush with a block.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr(0, 16'h2000);
        wr(1, 16'h2000);
        base = got.size();
        blk(ramp());
        drive(1'b1, ramp(), 1'b0, 1'b1, 4'd0, 16'h4000);
        drive(1'b1, fill(16'h2000), 1'b1, 1'b1, 4'd1, 16'h0000);
        blk(fill(16'h2000));
        idle(4);
        $display("coef/flush: %0d output blocks", got.size() - base);
        chk_lit("cf_a_l0", base + 0, 0, 16'h0100);
        chk_lit("cf_a_l2", base + 0, 2, 16'h0500);
        chk_lit("cf_b_l0_oldh", base + 1, 0, 16'h0700);
        chk_lit("cf_flush_l0", base + 2, 0, 16'h1000);
        chk_lit("cf_flush_l1", base + 2, 1, 16'h1800);
        chk_lit("cf_after_l0", base + 3, 0, 16'h1000);
        chk_lit("cf_after_l3", base + 3, 3, 16'h1000);

        // Reset with blocks in flight; coefficients are cleared by it.
        load_ramp_coefs();
        blk(impulse());
        blk(impulse());
        rst = 1'b1;
        tick();
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_y_blk", 128'(y_blk), 128'(0));
        rst = 1'b0;
        base = got.size();
        blk(impulse());
        for (int b = 0; b < 3; b++) blk('0);
        idle(4);
        $display("post-reset impulse: %0d output blocks", got.size() - base);
        check("rst_block_count", 128'(got.size() - base), 128'(4));
        chk_lit("rst_b0_l1", base + 0, 1, 16'd0);
        chk_lit("rst_b2_l3", base + 2, 3, 16'd0);

        load_ramp_coefs();
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
        base = got.size();
        blk(impulse());
        idle(4);
        chk_lit("reload_b0_l1", base + 0, 1, 16'd256);

        idle(3);
        check("expected_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
